core_muldiv_unit: RTL

Parametrised M-extension functional unit for the EX stage. It replaces the fixed 2-stage multiplier with a configurable pipelined multiplier and a radix-2 iterative divider. It uses a valid/ready request handshake and a single-pulse response. The EX stage drives the operands after forwarding, and stalls on `req_ready_o`/`busy_o` until `resp_valid_o`.

---
 rtl/core_muldiv_unit_if.sv | 24 ++
 rtl/core_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_muldiv_unit_if.sv
// Request/response bundle between the EX stage (master) and the M-extension unit (slave).
interface core_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic            flush_i;
  logic            resp_valid_o;
  logic [XLEN-1:0] resp_result_o;
  logic            busy_o;

  modport slave (
    input  req_valid_i, funct3_i, op1_i, op2_i, flush_i,
    output req_ready_o, resp_valid_o, resp_result_o, busy_o
  );

  modport master (
    output req_valid_i, funct3_i, op1_i, op2_i, flush_i,
    input  req_ready_o, resp_valid_o, resp_result_o, busy_o
  );
endinterface

// File: rtl/core_muldiv_unit.sv
// M-extension unit: MUL_STAGES-latency multiplier plus radix-2 restoring divider.
// Optional last-division result cache enabled by defining CORE_MULDIV_DIVCACHE_EN.
module core_muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  core_muldiv_unit_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(XLEN);
  localparam int unsigned PROD_W = 2 * XLEN + 2;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d, want_rem_q, want_rem_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              resp_valid_q, resp_valid_d;
  logic              ready_q, ready_d;

`ifdef CORE_MULDIV_DIVCACHE_EN
  logic              dc_valid_q, dc_valid_d, dc_sgn_q, dc_sgn_d, run_sgn_q, run_sgn_d;
  logic [XLEN-1:0]   dc_op1_q, dc_op1_d, dc_op2_q, dc_op2_d;
  logic [XLEN-1:0]   dc_quo_q, dc_quo_d, dc_rem_q, dc_rem_d;
  logic [XLEN-1:0]   run_op1_q, run_op1_d, run_op2_q, run_op2_d;
  logic              dc_hit;
`endif

  logic [2:0]        f3;
  logic              accept, div_signed, neg1, neg2, div_zero, div_ovf;
  logic [XLEN-1:0]   mag1, mag2, zero_res, ovf_res, mul_res;
  logic signed [XLEN:0]   m_a, m_b;
  logic signed [PROD_W-1:0] prod;
  logic [1:0]        unused_prod;
  logic [XLEN:0]     rem_sh, diff;
  logic              step_ge;
  logic [XLEN-1:0]   rem_nx, quo_nx, quo_fix, rem_fix;

  assign f3     = bus.funct3_i;
  assign accept = bus.req_valid_i & ready_q & ~bus.flush_i;

  // Operand extension: one extra bit carries the sign (or zero) for MULHSU.
  assign m_a         = {(f3[1:0] != 2'b11) & bus.op1_i[XLEN-1], bus.op1_i};
  assign m_b         = {~f3[1] & bus.op2_i[XLEN-1], bus.op2_i};
  assign prod        = PROD_W'(m_a) * PROD_W'(m_b);
  assign mul_res     = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign unused_prod = prod[PROD_W-1 -: 2];

  assign div_signed = ~f3[0];
  assign neg1       = div_signed & bus.op1_i[XLEN-1];
  assign neg2       = div_signed & bus.op2_i[XLEN-1];
  assign mag1       = neg1 ? (~bus.op1_i + XLEN'(1)) : bus.op1_i;
  assign mag2       = neg2 ? (~bus.op2_i + XLEN'(1)) : bus.op2_i;
  assign div_zero   = (bus.op2_i == '0);
  assign div_ovf    = div_signed & (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op2_i);
  assign zero_res   = f3[1] ? bus.op1_i : '1;
  assign ovf_res    = f3[1] ? '0 : bus.op1_i;

  // One restoring step on the XLEN+1 bit partial remainder.
  assign rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign step_ge = ~diff[XLEN];
  assign rem_nx  = step_ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx  = {quo_q[XLEN-2:0], step_ge};
  assign quo_fix = q_neg_q ? (~quo_nx + XLEN'(1)) : quo_nx;
  assign rem_fix = r_neg_q ? (~rem_nx + XLEN'(1)) : rem_nx;

`ifdef CORE_MULDIV_DIVCACHE_EN
  assign dc_hit = dc_valid_q & (dc_op1_q == bus.op1_i) & (dc_op2_q == bus.op2_i)
                & (dc_sgn_q == div_signed);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    dvs_d        = dvs_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    want_rem_d   = want_rem_q;
    res_d        = res_q;
    resp_valid_d = 1'b0;
`ifdef CORE_MULDIV_DIVCACHE_EN
    dc_valid_d = dc_valid_q;
    dc_sgn_d   = dc_sgn_q;
    dc_op1_d   = dc_op1_q;
    dc_op2_d   = dc_op2_q;
    dc_quo_d   = dc_quo_q;
    dc_rem_d   = dc_rem_q;
    run_op1_d  = run_op1_q;
    run_op2_d  = run_op2_q;
    run_sgn_d  = run_sgn_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!f3[2]) begin
            if (MUL_STAGES == 1) begin
              res_d        = mul_res;
              resp_valid_d = 1'b1;
              state_d      = S_DONE;
            end else begin
              quo_d   = mul_res;
              cnt_d   = '0;
              state_d = S_MUL;
            end
          end else if (div_zero || div_ovf) begin
            res_d        = div_zero ? zero_res : ovf_res;
            resp_valid_d = 1'b1;
            state_d      = S_DONE;
`ifdef CORE_MULDIV_DIVCACHE_EN
          end else if (dc_hit) begin
            res_d        = f3[1] ? dc_rem_q : dc_quo_q;
            resp_valid_d = 1'b1;
            state_d      = S_DONE;
`endif
          end else begin
            quo_d      = mag1;
            rem_d      = '0;
            dvs_d      = mag2;
            q_neg_d    = neg1 ^ neg2;
            r_neg_d    = neg1;
            want_rem_d = f3[1];
            cnt_d      = '0;
            state_d    = S_DIV;
`ifdef CORE_MULDIV_DIVCACHE_EN
            run_op1_d  = bus.op1_i;
            run_op2_d  = bus.op2_i;
            run_sgn_d  = div_signed;
`endif
          end
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_STAGES - 2)) begin
          res_d        = quo_q;
          resp_valid_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DIV: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          res_d        = want_rem_q ? rem_fix : quo_fix;
          resp_valid_d = 1'b1;
          state_d      = S_DONE;
`ifdef CORE_MULDIV_DIVCACHE_EN
          dc_valid_d = 1'b1;
          dc_op1_d   = run_op1_q;
          dc_op2_d   = run_op2_q;
          dc_sgn_d   = run_sgn_q;
          dc_quo_d   = quo_fix;
          dc_rem_d   = rem_fix;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A killed op must leave neither a pulse, a new result nor a cache entry behind.
    if (bus.flush_i && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      res_d        = res_q;
      resp_valid_d = 1'b0;
`ifdef CORE_MULDIV_DIVCACHE_EN
      dc_valid_d = dc_valid_q;
      dc_op1_d   = dc_op1_q;
      dc_op2_d   = dc_op2_q;
      dc_sgn_d   = dc_sgn_q;
      dc_quo_d   = dc_quo_q;
      dc_rem_d   = dc_rem_q;
`endif
    end
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      dvs_q        <= '0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      want_rem_q   <= 1'b0;
      res_q        <= '0;
      resp_valid_q <= 1'b0;
      ready_q      <= 1'b1;
`ifdef CORE_MULDIV_DIVCACHE_EN
      dc_valid_q <= 1'b0;
      dc_sgn_q   <= 1'b0;
      dc_op1_q   <= '0;
      dc_op2_q   <= '0;
      dc_quo_q   <= '0;
      dc_rem_q   <= '0;
      run_op1_q  <= '0;
      run_op2_q  <= '0;
      run_sgn_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      dvs_q        <= dvs_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
      want_rem_q   <= want_rem_d;
      res_q        <= res_d;
      resp_valid_q <= resp_valid_d;
      ready_q      <= ready_d;
`ifdef CORE_MULDIV_DIVCACHE_EN
      dc_valid_q <= dc_valid_d;
      dc_sgn_q   <= dc_sgn_d;
      dc_op1_q   <= dc_op1_d;
      dc_op2_q   <= dc_op2_d;
      dc_quo_q   <= dc_quo_d;
      dc_rem_q   <= dc_rem_d;
      run_op1_q  <= run_op1_d;
      run_op2_q  <= run_op2_d;
      run_sgn_q  <= run_sgn_d;
`endif
    end
  end

  assign bus.req_ready_o   = ready_q;
  assign bus.busy_o        = ~ready_q;
  assign bus.resp_valid_o  = resp_valid_q;
  assign bus.resp_result_o = res_q;

endmodule
